alu_sequencer: RTL and testbench

- Front-end controller for the 16-bit logic unit (ALU with result store and pipelined divider core).
- Accepts one operation request at a time over a valid/ready handshake and drives the operands onto bus1/bus2.
- Sequences the one-hot ALU control strobes, including the EXEC→push two-step and the divider latency wait.
- Captures the bus3/bus4 results and returns them over a valid/ready response handshake.

---
 rtl/alu_sequencer_if.sv | 32 +++
 rtl/alu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response handshake plus the operand, result and strobe buses between
// the sequencer (slave side) and its requester / ALU (master side).
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_lo;
    logic [15:0] rsp_hi;
    logic        rsp_err;
    logic        busy;
    logic [15:0] alu_bus1;
    logic [15:0] alu_bus2;
    logic [15:0] alu_bus3;
    logic [15:0] alu_bus4;
    logic [18:0] alu_ctl;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_bus3, alu_bus4,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err, busy,
               alu_bus1, alu_bus2, alu_ctl
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_bus3, alu_bus4,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err, busy,
               alu_bus1, alu_bus2, alu_ctl
    );
endinterface

// File: rtl/alu_sequencer.sv
// Front-end sequencer for the 16-bit logic unit: accepts one request, drives the
// operand buses, steps the one-hot ALU strobes and returns the captured results.
module alu_sequencer #(
    parameter int DIV_LATENCY = 20,
    parameter int CW          = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  ifc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        DIV_WAIT = 3'd2,
        CAPTURE  = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [3:0]  OP_LAST_ALU = 4'd10;
    localparam logic [3:0]  OP_DIV      = 4'd11;
    localparam logic [3:0]  OP_PASS     = 4'd12;
    localparam logic [3:0]  OP_SWAP     = 4'd13;

    localparam logic [18:0] CTL_NONE     = 19'h00000;
    localparam logic [18:0] CTL_PASS     = 19'h00007;  // passh + passl + pass_high
    localparam logic [18:0] CTL_SWAP     = 19'h00008;
    localparam logic [18:0] CTL_PUSH     = 19'h00030;  // push + push_high
    localparam logic [18:0] CTL_PUSH_DIV = 19'h00040;
    localparam logic [18:0] CTL_PUSH_MOD = 19'h00080;

    state_t      state_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]  op_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [18:0] ctl_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic [15:0] rsp_lo_reg;
    logic [15:0] rsp_hi_reg;
    logic        div_mod_reg;

    logic [10:0] exec_sel;
    logic [18:0] exec_ctl;
    logic        accept;
    logic        div_by_zero;

    // Opcodes 0..10 map in order onto strobe bits 8..18 (add .. bnegate).
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_exec_sel
            assign exec_sel[gi] = (ifc.req_op == 4'(gi));
        end
    endgenerate

    assign exec_ctl    = {exec_sel, 8'h00};
    assign accept      = ifc.req_valid && ifc.req_ready;
    assign div_by_zero = (b_reg == 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_reg        <= 4'd0;
            a_reg         <= 16'h0000;
            b_reg         <= 16'h0000;
            ctl_reg       <= CTL_NONE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_lo_reg    <= 16'h0000;
            rsp_hi_reg    <= 16'h0000;
            div_mod_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg       <= ifc.req_a;
                        b_reg       <= ifc.req_b;
                        op_reg      <= ifc.req_op;
                        rsp_err_reg <= 1'b0;
                        div_mod_reg <= 1'b0;
                        if (ifc.req_op <= OP_LAST_ALU) begin
                            state_reg <= EXEC;
                            ctl_reg   <= exec_ctl;
                        end else if (ifc.req_op == OP_DIV) begin
                            state_reg <= DIV_WAIT;
                            cnt_reg   <= CW'(DIV_LATENCY - 1);
                            ctl_reg   <= CTL_NONE;
                        end else if (ifc.req_op == OP_PASS) begin
                            state_reg <= CAPTURE;
                            ctl_reg   <= CTL_PASS;
                        end else if (ifc.req_op == OP_SWAP) begin
                            state_reg <= CAPTURE;
                            ctl_reg   <= CTL_SWAP;
                        end else begin
                            state_reg     <= RESP;
                            ctl_reg       <= CTL_NONE;
                            rsp_valid_reg <= 1'b1;
                            rsp_lo_reg    <= 16'h0000;
                            rsp_hi_reg    <= 16'h0000;
                            rsp_err_reg   <= 1'b1;
                        end
                    end
                end

                EXEC: begin
                    state_reg <= CAPTURE;
                    ctl_reg   <= CTL_PUSH;
                end

                DIV_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= CAPTURE;
                        ctl_reg   <= CTL_PUSH_DIV;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                CAPTURE: begin
                    if (op_reg == OP_DIV) begin
                        // Quotient and remainder share bus4, so DIV spends two capture cycles.
                        if (!div_mod_reg) begin
                            rsp_lo_reg  <= div_by_zero ? 16'hFFFF : ifc.alu_bus4;
                            ctl_reg     <= CTL_PUSH_MOD;
                            div_mod_reg <= 1'b1;
                        end else begin
                            rsp_hi_reg    <= div_by_zero ? a_reg : ifc.alu_bus4;
                            rsp_err_reg   <= div_by_zero;
                            ctl_reg       <= CTL_NONE;
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                        end
                    end else begin
                        rsp_lo_reg    <= ifc.alu_bus3;
                        rsp_hi_reg    <= ifc.alu_bus4;
                        ctl_reg       <= CTL_NONE;
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                    end
                end

                RESP: begin
                    if (ifc.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    ctl_reg   <= CTL_NONE;
                end
            endcase
        end
    end

    // Held low while reset is asserted so nothing is accepted during reset.
    assign ifc.req_ready = rst_n && (state_reg == IDLE);
    assign ifc.busy      = (state_reg != IDLE);
    assign ifc.rsp_valid = rsp_valid_reg;
    assign ifc.rsp_lo    = rsp_lo_reg;
    assign ifc.rsp_hi    = rsp_hi_reg;
    assign ifc.rsp_err   = rsp_err_reg;
    assign ifc.alu_bus1  = a_reg;
    assign ifc.alu_bus2  = b_reg;
    assign ifc.alu_ctl   = ctl_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random transactions against alu_sequencer with a behavioural ALU
// (result store + divider) and an opcode-level reference for results and timing.
module tb_alu_sequencer;

    localparam int DL = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if sif();

    alu_sequencer #(.DIV_LATENCY(DL), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (sif)
    );

    int total = 0;
    int bad   = 0;

    // 32-bit result of ALU operation k (0 ADD .. 10 NOT): {high word, low word}.
    function automatic logic [31:0] alu_calc(input int k, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = {16'h0000, a};
        eb = {16'h0000, b};
        case (k)
            0:  return ea + eb;
            1:  return ea - eb;
            2:  return ea + 32'd1;
            3:  return ea - 32'd1;
            4:  return ea * eb;
            5:  return {16'h0000, a >> 1};
            6:  return ea << 1;
            7:  return {16'h0000, a & b};
            8:  return {16'h0000, a | b};
            9:  return {16'h0000, a ^ b};
            10: return {16'h0000, ~a};
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural ALU: strobes load the result store, push strobes drive it out.
    logic [31:0] store;
    logic [15:0] b3;
    logic [15:0] b4;

    always @(posedge clk) begin
        for (int k = 0; k < 11; k++)
            if (sif.alu_ctl[8 + k]) store <= alu_calc(k, sif.alu_bus1, sif.alu_bus2);
    end

    always_comb begin
        b3 = 16'hDEAD;
        b4 = 16'hBEEF;
        if (sif.alu_ctl[4]) b3 = store[15:0];
        if (sif.alu_ctl[5]) b4 = store[31:16];
        if (sif.alu_ctl[2:0] == 3'b111) begin
            b3 = sif.alu_bus1;
            b4 = sif.alu_bus2;
        end
        if (sif.alu_ctl[3]) begin
            b3 = sif.alu_bus2;
            b4 = sif.alu_bus1;
        end
        if (sif.alu_ctl[6]) b4 = (sif.alu_bus2 != 16'h0) ? sif.alu_bus1 / sif.alu_bus2 : 16'h0BAD;
        if (sif.alu_ctl[7]) b4 = (sif.alu_bus2 != 16'h0) ? sif.alu_bus1 % sif.alu_bus2 : 16'h0BAD;
    end

    assign sif.alu_bus3 = b3;
    assign sif.alu_bus4 = b4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [18:0] exp_q[$];
        logic [18:0] got_q[$];
        logic [31:0] r;
        logic [15:0] elo;
        logic [15:0] ehi;
        logic        eerr;
        int          elat;
        int          lat;
        logic        bus_bad;

        elo = 16'h0; ehi = 16'h0; eerr = 1'b0; bus_bad = 1'b0;
        if (op <= 4'd10) begin
            r = alu_calc(int'(op), a, b);
            elo = r[15:0];
            ehi = r[31:16];
            elat = 3;
            exp_q.push_back(19'(1) << (8 + int'(op)));
            exp_q.push_back(19'h00030);
        end else if (op == 4'd11) begin
            elat = DL + 3;
            repeat (DL) exp_q.push_back(19'h0);
            exp_q.push_back(19'h00040);
            exp_q.push_back(19'h00080);
            if (b == 16'h0) begin
                elo = 16'hFFFF; ehi = a; eerr = 1'b1;
            end else begin
                elo = a / b; ehi = a % b;
            end
        end else if (op == 4'd12) begin
            elat = 2;
            exp_q.push_back(19'h00007);
            elo = a; ehi = b;
        end else if (op == 4'd13) begin
            elat = 2;
            exp_q.push_back(19'h00008);
            elo = b; ehi = a;
        end else begin
            elat = 1;
            eerr = 1'b1;
        end

        @(negedge clk);
        chk("req_ready_idle", sif.req_ready, 1);
        sif.req_valid = 1'b1;
        sif.req_op    = op;
        sif.req_a     = a;
        sif.req_b     = b;
        sif.rsp_ready = (hold == 0);
        @(negedge clk);
        sif.req_valid = 1'b0;
        chk("err_at_accept", sif.rsp_err, (op >= 4'd14) ? 1 : 0);

        lat = 1;
        while (sif.rsp_valid !== 1'b1 && lat < DL + 10) begin
            got_q.push_back(sif.alu_ctl);
            if (sif.alu_bus1 !== a || sif.alu_bus2 !== b) bus_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (sif.rsp_valid !== 1'b1) begin
            chk("rsp_timeout", sif.rsp_valid, 1);
            sif.rsp_ready = 1'b1;
            return;
        end

        $display("op=%0d a=%h b=%h -> lo=%h hi=%h err=%b lat=%0d", op, a, b,
                 sif.rsp_lo, sif.rsp_hi, sif.rsp_err, lat);
        chk("latency", lat, elat);
        chk("operand_bus_held", bus_bad, 0);
        chk("ctl_len", got_q.size(), exp_q.size());
        if (got_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("ctl_cyc%0d", i + 1), got_q[i], exp_q[i]);
        chk("ctl_in_resp", sif.alu_ctl, 0);
        chk("rsp_lo", sif.rsp_lo, elo);
        chk("rsp_hi", sif.rsp_hi, ehi);
        chk("rsp_err", sif.rsp_err, eerr);
        chk("busy_ready_in_resp", {sif.busy, sif.req_ready}, 2'b10);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_stable", {sif.rsp_valid, sif.req_ready, sif.rsp_err, sif.rsp_hi, sif.rsp_lo},
                {1'b1, 1'b0, eerr, ehi, elo});
        end
        sif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release", {sif.rsp_valid, sif.busy, sif.req_ready}, 3'b001);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        seen;

        sif.req_valid = 1'b1;
        sif.req_op    = 4'd15;
        sif.req_a     = 16'h0;
        sif.req_b     = 16'h0;
        sif.rsp_ready = 1'b1;
        rst_n = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_ctl", {sif.req_ready, sif.rsp_valid, sif.busy, sif.rsp_err, sif.alu_ctl}, 0);
            chk("reset_data", {sif.alu_bus1, sif.alu_bus2, sif.rsp_lo, sif.rsp_hi}, 0);
        end
        sif.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", {sif.req_ready, sif.busy, sif.rsp_valid}, 3'b100);

        // Directed cases
        run_op(4'd0,  16'h1234, 16'h0001, 0);
        run_op(4'd0,  16'hFFFF, 16'h0001, 0);
        run_op(4'd11, 16'd100,  16'd7,    0);
        run_op(4'd11, 16'd100,  16'd0,    0);
        run_op(4'd13, 16'hAAAA, 16'h5555, 0);
        run_op(4'd15, 16'h1111, 16'h2222, 0);
        run_op(4'd12, 16'hCAFE, 16'hF00D, 0);
        run_op(4'd4,  16'h1234, 16'h5678, 5);
        run_op(4'd3,  16'h0000, 16'h0000, 0);
        run_op(4'd6,  16'h8001, 16'h0000, 2);

        // Reset during DIV_WAIT abandons the operation
        @(negedge clk);
        sif.req_valid = 1'b1;
        sif.req_op    = 4'd11;
        sif.req_a     = 16'd500;
        sif.req_b     = 16'd3;
        @(negedge clk);
        sif.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_in_div_wait", sif.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset", {sif.busy, sif.rsp_valid, sif.req_ready, sif.alu_ctl}, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (DL + 5) begin
            @(negedge clk);
            if (sif.rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("no_rsp_after_reset", seen, 0);
        run_op(4'd0, 16'h0F0F, 16'h0101, 0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
